// File: rtl/pinpad_pkg.sv
// pinpad_pkg
//   Shared definitions for the 4x4 pin-pad scanner: scan FSM state
//   encoding, matrix geometry, key-code width and small decode helpers.
package pinpad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Index of the lowest active row; returns 0 when no row is active,
    // so callers must qualify the result with |rows.
    function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] rows);
        lowest_row = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) lowest_row = 2'(i);
        end
    endfunction

    // One-hot active-low column drive pattern for a column index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        col_drive = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/pinpad_fifo.sv
// pinpad_fifo
//   Small synchronous FIFO holding accepted key codes.
//   Ports:
//     clk, reset     clock and synchronous active-high reset
//     push/push_data write request and data (dropped when full without pop)
//     pop            read request (ignored when empty)
//     clear          synchronous flush; a push in the same cycle is discarded
//     head           oldest entry, zero while empty
//     count          entries held, 0..DEPTH
//     full, empty    occupancy flags
module pinpad_fifo
    import pinpad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = KEY_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !clear;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push && !clear && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; head is masked while empty, so stale
    // contents are never visible and the array can map to plain RAM/LUTs.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: all state updates use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pinpad_scanner.sv
// pinpad_scanner
//   Scans a 4x4 key matrix one column at a time, debounces presses and
//   releases, and queues accepted key codes (row*4 + col) in a FIFO.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     col_o       column drive, one-hot active-low
//     row_i       row sense, active-high
//     key_code    FIFO head
//     key_valid   FIFO non-empty
//     key_ready   consumer pop (with key_valid)
//     fifo_count  entries queued
//     overflow    sticky: an accepted key was dropped because the FIFO was full
//     clear       synchronous flush of FIFO and overflow (scan FSM unaffected)
module pinpad_scanner
    import pinpad_pkg::*;
#(
    parameter int SETTLE_CYC = 500,
    parameter int DB_SAMPLES = 2000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [3:0]       col_o,
    input  logic [3:0]       row_i,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [2:0]       fifo_count,
    output logic             overflow,
    input  logic             clear
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int DW = $clog2(DB_SAMPLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    scan_state_t      state;
    logic [SW-1:0]    settle_cnt;
    logic [DW-1:0]    db_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       row_lat;

    logic             tick;
    logic             row_hit;
    logic [1:0]       row_idx;
    logic             match;
    logic [DW-1:0]    db_next;
    logic             db_done;
    logic [1:0]       next_col;
    logic             push_now;
    logic [KEY_W-1:0] push_code;
    logic             pop_now;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    count;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        tick      = (settle_cnt == SW'(SETTLE_CYC - 1));
        row_hit   = |row_i;
        row_idx   = lowest_row(row_i);
        match     = row_hit && (row_idx == row_lat);
        db_next   = db_cnt + DW'(1);
        db_done   = (db_next == DW'(DB_SAMPLES));
        next_col  = col_idx + 2'd1;
        push_now  = 1'b0;
        push_code = {row_lat, col_idx};
        if (tick) begin
            case (state)
                SCAN: begin
                    // Degenerate single-sample debounce accepts on the first hit.
                    push_now  = row_hit && (DB_SAMPLES <= 1);
                    push_code = {row_idx, col_idx};
                end
                DEBOUNCE: push_now = match && db_done;
                default:  push_now = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCAN;
            settle_cnt <= '0;
            db_cnt     <= '0;
            col_idx    <= 2'd0;
            col_o      <= col_drive(2'd0);
            row_lat    <= 2'd0;
        end else begin
            settle_cnt <= tick ? '0 : settle_cnt + SW'(1);
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_hit) begin
                            // Column stays frozen on col_idx while the key is tracked.
                            row_lat <= row_idx;
                            if (DB_SAMPLES <= 1) begin
                                state  <= HELD;
                                db_cnt <= '0;
                            end else begin
                                state  <= DEBOUNCE;
                                db_cnt <= DW'(1);
                            end
                        end else begin
                            col_idx <= next_col;
                            col_o   <= col_drive(next_col);
                        end
                    end
                    DEBOUNCE: begin
                        if (match) begin
                            if (db_done) begin
                                state  <= HELD;
                                db_cnt <= '0;
                            end else begin
                                db_cnt <= db_next;
                            end
                        end else begin
                            state   <= SCAN;
                            db_cnt  <= '0;
                            col_idx <= next_col;
                            col_o   <= col_drive(next_col);
                        end
                    end
                    HELD: begin
                        // Any activity on the frozen column restarts the release count;
                        // no new code is pushed until the release completes.
                        if (!row_hit) begin
                            if (db_done) begin
                                state   <= SCAN;
                                db_cnt  <= '0;
                                col_idx <= next_col;
                                col_o   <= col_drive(next_col);
                            end else begin
                                db_cnt <= db_next;
                            end
                        end else begin
                            db_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign pop_now = key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow <= 1'b0;
        end else if (push_now && fifo_full && !pop_now) begin
            overflow <= 1'b1;
        end
    end

    pinpad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_now),
        .push_data (push_code),
        .pop       (key_ready),
        .clear     (clear),
        .head      (key_code),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign key_valid  = !fifo_empty;
    assign fifo_count = 3'(count);

endmodule

// File: doc/pinpad_scanner.md
PINPAD_SCANNER -- requirements
Module: pinpad_scanner

Interface
REQ-001 Parameter SETTLE_CYC, default 500, sets the cycles each column is driven before its row sample (10 us at 50 MHz).
REQ-002 Parameter DB_SAMPLES, default 2000, sets the consecutive matching samples needed to accept a press or a release.
REQ-003 Parameter FIFO_DEPTH, default 4, sets the key-code FIFO entries; it SHALL be a power of two.
REQ-004 Port clk, input, 1 bit: the single clock, from CLOCK_50.
REQ-005 Port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-006 Port col_o, output, 4 bits: column drive, one-hot active-low; bit n low drives column n.
REQ-007 Port row_i, input, 4 bits: row sense, active-high, already inverted upstream.
REQ-008 Port key_code, output, 4 bits: FIFO head; code = row_index*4 + col_index.
REQ-009 Port key_valid, output, 1 bit: FIFO non-empty.
REQ-010 Port key_ready, input, 1 bit: consumer pops the head when key_valid and key_ready are both high.
REQ-011 Port fifo_count, output, 3 bits: entries held, 0..FIFO_DEPTH.
REQ-012 Port overflow, output, 1 bit: sticky flag, set when an accepted key is dropped.
REQ-013 Port clear, input, 1 bit: synchronous flush of the FIFO and of overflow.

Function
REQ-014 The scanner SHALL implement three states: SCAN, DEBOUNCE and HELD.
REQ-015 A settle counter SHALL count 0..SETTLE_CYC-1 and row_i SHALL be sampled only on the cycle the counter equals SETTLE_CYC-1 (the "sample tick").
REQ-016 In SCAN, on a sample tick:
  - if row_i is zero, col_o SHALL advance to the next column (3 wraps to 0);
  - otherwise the FSM SHALL latch the column and the lowest set row index, set db_cnt=1 and enter DEBOUNCE.
REQ-017 In DEBOUNCE and HELD, col_o SHALL stay on the latched column.
REQ-018 In DEBOUNCE, on each sample tick:
  - if the lowest set row index equals the latched row, db_cnt SHALL increment;
  - otherwise the FSM SHALL return to SCAN with col_o advanced.
REQ-019 When db_cnt reaches DB_SAMPLES, the scanner SHALL push the code into the FIFO once and enter HELD with db_cnt=0.
REQ-020 In HELD, on each sample tick, row_i==0 SHALL increment db_cnt and any other value SHALL zero it.
REQ-021 In HELD, when db_cnt reaches DB_SAMPLES, the FSM SHALL return to SCAN with col_o advanced. Auto-repeat SHALL NOT occur.
REQ-022 When multiple rows are active, the lowest index SHALL win. A second key pressed while in HELD SHALL be ignored until release.
REQ-023 FIFO write-to-read latency SHALL be 1 cycle: key_valid rises on the cycle after the push.
REQ-024 key_code SHALL hold stable while key_valid is high and key_ready is low.
REQ-025 A push with the FIFO full and no pop in the same cycle SHALL drop the code and set overflow. A simultaneous push and pop when full SHALL succeed with the count unchanged.
REQ-026 A pop when empty SHALL be ignored.
REQ-027 clear SHALL empty the FIFO and clear overflow on the next edge. A push coinciding with clear SHALL be discarded.
REQ-028 clear SHALL NOT affect the scan FSM.

Reset
REQ-029 On reset the outputs SHALL be: state SCAN, col_o=4'b1110, settle counter 0, db_cnt 0, FIFO empty, key_valid 0, key_code 0, fifo_count 0, overflow 0.
REQ-030 Reset asserted mid-debounce or mid-hold SHALL abandon the press with no push.
REQ-031 Reset SHALL take priority over clear and over all handshakes.

Structure
REQ-032 Package pinpad_pkg SHALL hold the FSM state enum, NUM_COLS=4, NUM_ROWS=4 and KEY_W=4.
REQ-033 The FIFO SHALL be the sub-module pinpad_fifo (push/pop/clear, count, full, empty), instantiated once.
REQ-034 Target size is 120-400 lines of RTL in total.

Verification (SETTLE_CYC=4, DB_SAMPLES=3, FIFO_DEPTH=4)
REQ-035 No key held from reset release -> col_o cycles 1110, 1101, 1011, 0111, changing every 4 cycles; key_valid stays 0.
REQ-036 row_i=4'b0100 whenever col_o[1]==0, released after 40 cycles -> exactly one entry, key_code=4'h9 (row 2, col 1), key_valid rises 1 cycle after the third matching sample.
REQ-037 Bounce: row present for 1 sample, absent for 1 sample, then stable -> no push on the bounce; a single push after 3 stable samples.
REQ-038 Five distinct presses with key_ready=0 -> fifo_count=4, overflow=1, head code = first key; then key_ready=1 for 4 cycles -> codes delivered in press order, fifo_count=0, overflow still 1 until clear.
REQ-039 Reset pulsed during DEBOUNCE on code 4'h0 -> no entry; col_o returns to 1110.
REQ-040 Rows 0 and 3 both active on column 2 -> code 4'h2 (lowest row wins).
